evt_buf_fifo: RTL and testbench
===============================

Name: evt_buf_fifo

Overview:
- Parametrised event-framed FIFO buffer for tracker/energy data in the event builder; successor to the fixed 256x12 event buffer RAM.
- Writer streams words and marks the last word of each event.
- Reader sees only fully committed events.
- Partial events can be aborted or are auto-discarded on overflow, so downstream never reads a truncated event.

Parameters:
- DW, 12, data word width.
- AW, 8, address width; depth = 2**AW words.

Ports:
- Clock  in  1  system clock; all logic on rising edge.
- ResetN  in  1  asynchronous active-low reset.
- WrEn  in  1  write strobe for WrData.
- WrData  in  DW  word to store.
- WrLast  in  1  qualifies WrEn: this word ends the event.
- WrAbort  in  1  discard the event currently being written.
- Full  out  1  no free word; combinational from registered pointers.
- Overflow  out  1  sticky: an event was dropped for lack of space.
- RdEn  in  1  read request.
- RdData  out  DW  read word, valid when RdValid.
- RdValid  out  1  RdData valid this cycle.
- RdLast  out  1  with RdValid: last word of the event.
- EvtAvail  out  1  at least one committed, unread word exists.
- NEvt  out  AW+1  count of committed events whose last word has not yet been output.
- Occupancy  out  AW+1  words held, including the uncommitted partial event.

Behaviour:
- Reset (async, ResetN=0):
  - Pointers, NEvt, Occupancy, RdData, RdValid, RdLast, Overflow and EvtAvail all clear to 0; Full=0.
  - Write FSM goes to IDLE.
  - RAM array is not reset.
  - Reset mid-event discards everything.
- Pointers are AW+1 bits:
  - wr_ptr: speculative write pointer.
  - wr_cmt: committed write pointer.
  - rd_ptr: read pointer.
  - Full = (wr_ptr - rd_ptr) == 2**AW.
  - EvtAvail = (rd_ptr != wr_cmt).
  - Occupancy = wr_ptr - rd_ptr.
- RAM word = {last_flag, data}, width DW+1.
- Write FSM states:
  - IDLE: no partial event pending.
    - WrEn & !Full: store the word, wr_ptr+1.
    - If WrLast: wr_cmt <= new wr_ptr, NEvt+1, stay IDLE; else go to FILL.
  - FILL: partial event pending.
    - WrEn & !Full: store the word, wr_ptr+1.
    - If WrLast: commit as above, go to IDLE.
    - WrAbort: wr_ptr <= wr_cmt, go to IDLE. Abort beats a same-cycle WrEn, including WrEn&WrLast; that word is discarded.
  - Overflow entry (WrEn & Full in IDLE or FILL): word dropped, wr_ptr <= wr_cmt, Overflow <= 1.
    - If WrLast is set on the dropped word: go to IDLE; else go to DROP.
  - DROP: all writes ignored until WrEn&WrLast or WrAbort, then go to IDLE. Full is still reported truthfully.
  - WrAbort in IDLE: no effect.
- Read side:
  - RdEn & EvtAvail: RAM read at rd_ptr, rd_ptr+1.
  - Next cycle: RdValid=1, RdData/RdLast from RAM (1-cycle latency, registered outputs).
  - RdEn & !EvtAvail: ignored; RdValid=0 next cycle.
  - RdValid deasserts the cycle after any non-accepted RdEn.
  - Full throughput: one word per clock.
- NEvt:
  - +1 on commit; -1 when RdValid&RdLast is output.
  - Both in the same cycle: unchanged.
  - Range 0..2**AW (one-word events).
- Occupancy and Full react to the same-cycle write (wr_ptr) and read (rd_ptr) updates on the next edge.
  - Simultaneous read and write while Full: the write is dropped, because Full is evaluated on pre-edge pointers.
- An event longer than the free space always ends in DROP with Overflow set. An event longer than 2**AW can never be stored.
- Wrap-around: pointers roll over modulo 2**(AW+1); the RAM address is ptr[AW-1:0].
- Read-during-write to the same RAM address cannot occur; the reader only reaches committed addresses.

Decomposition:
- Package evt_buf_pkg:
  - write-FSM state enum (IDLE, FILL, DROP);
  - function for the pointer-difference occupancy.
- Sub-module evt_buf_ram:
  - simple dual-port RAM, 2**AW x (DW+1);
  - one write port, one registered read port with read enable;
  - single Clock, no reset on the array.
- Top level holds the pointers, FSM, counters and flags.

Test Plan (DW=12, AW=4, depth 16):
- Write 3-word event 0x001,0x002,0x003 (last on 3rd); check EvtAvail only after the 3rd edge. Hold RdEn 4 cycles -> RdValid for 3 cycles with data 0x001,0x002,0x003, RdLast on 0x003; NEvt goes 1 -> 0.
- Write 2 words, then WrAbort with WrEn&WrLast in the same cycle -> Occupancy returns to 0, NEvt=0, EvtAvail=0; the next event written reads back intact.
- Commit a 10-word event, then write a 9-word event with no reads -> Full after word 6 of event 2; word 7 sets Overflow=1; Occupancy returns to 10; words 8-9 ignored (DROP); NEvt=1; event 1 reads back intact.
- Stream 40 one-word events while the reader drains continuously -> pointers wrap 2+ times, no loss, data in order, NEvt never exceeds 2, Overflow stays 0.
- Same-cycle commit and RdLast output with NEvt=1 -> NEvt stays 1. RdEn while EvtAvail=0 -> RdValid stays 0.
- Assert ResetN=0 asynchronously mid-event and mid-read -> all outputs 0 immediately; after release, a fresh event round-trips correctly.

Source files
------------

// File: rtl/evt_buf_pkg.sv
// evt_buf_pkg: shared types and helpers for the event-framed FIFO buffer.
//   wr_state_e : write-side framing FSM states.
//   ptr_diff   : modular distance between two wrapping pointers.
package evt_buf_pkg;

  // Write-side framing state.
  //   WR_IDLE : no partial event pending
  //   WR_FILL : a partial event is being written
  //   WR_DROP : the current event overflowed, swallow words until it ends
  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  // Distance a - b between two pointers that roll over modulo 2**pw.
  // Operands are zero-extended to 32 bits by the caller; the mask folds the
  // subtraction back into the pointer's own modulus.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int unsigned pw);
    logic [31:0] mask;
    mask = (32'd1 << pw) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/evt_buf_ram.sv
// evt_buf_ram: simple dual-port RAM, 2**AW words of W bits.
//   Clock            : clock for both ports
//   ResetN           : async active-low reset of the read register only
//   we_i/waddr_i/wdata_i : synchronous write port
//   re_i/raddr_i     : read request; data appears on rdata_o one cycle later
//   rdata_o          : registered read data, holds when re_i is low
// The storage array itself is never reset.
module evt_buf_ram #(
  parameter int W  = 13,
  parameter int AW = 8
) (
  input  logic          Clock,
  input  logic          ResetN,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  // Storage array write port.
  always_ff @(posedge Clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; the output register clears on reset so the
  // buffer's read data is 0 out of reset.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/evt_buf_fifo.sv
// evt_buf_fifo: event-framed FIFO. The writer streams words and flags the
// last word of each event; the reader only ever sees fully committed events.
// Partial events are discarded on WrAbort or when they run out of space.
//   Clock, ResetN        : clock, async active-low reset
//   WrEn/WrData/WrLast   : write strobe, word, end-of-event flag
//   WrAbort              : discard the event currently being written
//   Full                 : no free word (from registered pointers)
//   Overflow             : sticky, an event was dropped for lack of space
//   RdEn                 : read request
//   RdData/RdValid/RdLast: read word, valid, last-of-event (1-cycle latency)
//   EvtAvail             : committed unread words exist
//   NEvt                 : committed events whose last word is not yet output
//   Occupancy            : words held, including the uncommitted partial event
module evt_buf_fifo
  import evt_buf_pkg::*;
#(
  parameter int DW = 12,
  parameter int AW = 8
) (
  input  logic          Clock,
  input  logic          ResetN,
  input  logic          WrEn,
  input  logic [DW-1:0] WrData,
  input  logic          WrLast,
  input  logic          WrAbort,
  output logic          Full,
  output logic          Overflow,
  input  logic          RdEn,
  output logic [DW-1:0] RdData,
  output logic          RdValid,
  output logic          RdLast,
  output logic          EvtAvail,
  output logic [AW:0]   NEvt,
  output logic [AW:0]   Occupancy
);

  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0] ONE   = {{AW{1'b0}}, 1'b1};

  wr_state_e     state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;   // speculative write pointer
  logic [PW-1:0] wr_cmt_q, wr_cmt_d;   // end of last committed event
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] nevt_q, nevt_d;
  logic          ovf_q, ovf_d;
  logic          rd_valid_q;

  logic [PW-1:0] occ_s;
  logic          full_s;
  logic          evt_avail_s;
  logic          rd_accept_s;
  logic          ram_we_s;
  logic          commit_s;
  logic          rd_last_out_s;
  logic [DW:0]   ram_rdata_s;

  assign occ_s       = PW'(ptr_diff(32'(wr_ptr_q), 32'(rd_ptr_q), PW));
  assign full_s      = (occ_s == DEPTH);
  // The reader stops at the commit pointer, so it never touches a word of
  // the event still being written (no read-during-write hazard).
  assign evt_avail_s = (rd_ptr_q != wr_cmt_q);
  assign rd_accept_s = RdEn & evt_avail_s;
  assign rd_last_out_s = rd_valid_q & ram_rdata_s[DW];

  // Write framing FSM: next state, pointer updates, RAM write and commit.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    wr_cmt_d = wr_cmt_q;
    ovf_d    = ovf_q;
    ram_we_s = 1'b0;
    commit_s = 1'b0;
    case (state_q)
      WR_IDLE, WR_FILL: begin
        if ((state_q == WR_FILL) && WrAbort) begin
          // Abort wins over any same-cycle write, even one ending the event.
          wr_ptr_d = wr_cmt_q;
          state_d  = WR_IDLE;
        end else if (WrEn && !full_s) begin
          ram_we_s = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE;
          if (WrLast) begin
            wr_cmt_d = wr_ptr_q + ONE;
            commit_s = 1'b1;
            state_d  = WR_IDLE;
          end else begin
            state_d  = WR_FILL;
          end
        end else if (WrEn) begin
          // No room: roll back the partial event and swallow the rest of it.
          wr_ptr_d = wr_cmt_q;
          ovf_d    = 1'b1;
          state_d  = WrLast ? WR_IDLE : WR_DROP;
        end else begin
          state_d  = state_q;
        end
      end
      WR_DROP: begin
        if (WrAbort || (WrEn && WrLast)) begin
          state_d = WR_IDLE;
        end else begin
          state_d = WR_DROP;
        end
      end
      default: begin
        state_d  = WR_IDLE;
        wr_ptr_d = wr_cmt_q;
      end
    endcase
  end

  // Committed-event count: up on commit, down when an event's last word leaves.
  always_comb begin
    nevt_d = nevt_q;
    if (commit_s && !rd_last_out_s) begin
      nevt_d = nevt_q + ONE;
    end else if (!commit_s && rd_last_out_s) begin
      nevt_d = nevt_q - ONE;
    end else begin
      nevt_d = nevt_q;
    end
  end

  // State, pointer, counter and flag registers.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= WR_IDLE;
      wr_ptr_q   <= '0;
      wr_cmt_q   <= '0;
      rd_ptr_q   <= '0;
      nevt_q     <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      wr_cmt_q   <= wr_cmt_d;
      rd_ptr_q   <= rd_accept_s ? (rd_ptr_q + ONE) : rd_ptr_q;
      nevt_q     <= nevt_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_accept_s;
    end
  end

  // Each RAM word carries its end-of-event flag above the data.
  evt_buf_ram #(
    .W  (DW + 1),
    .AW (AW)
  ) u_ram (
    .Clock   (Clock),
    .ResetN  (ResetN),
    .we_i    (ram_we_s),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({WrLast, WrData}),
    .re_i    (rd_accept_s),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata_s)
  );

  assign Full      = full_s;
  assign Overflow  = ovf_q;
  assign RdData    = ram_rdata_s[DW-1:0];
  assign RdValid   = rd_valid_q;
  assign RdLast    = rd_last_out_s;
  assign EvtAvail  = evt_avail_s;
  assign NEvt      = nevt_q;
  assign Occupancy = occ_s;

endmodule

// File: tb/tb_evt_buf_fifo.sv
// tb_evt_buf_fifo: directed scenarios plus randomized traffic for evt_buf_fifo
// (DW=12, AW=4), checked each cycle against a queue-based event model.
module tb_evt_buf_fifo;

  localparam int DW    = 12;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          Clock;
  logic          ResetN;
  logic          WrEn;
  logic [DW-1:0] WrData;
  logic          WrLast;
  logic          WrAbort;
  logic          Full;
  logic          Overflow;
  logic          RdEn;
  logic [DW-1:0] RdData;
  logic          RdValid;
  logic          RdLast;
  logic          EvtAvail;
  logic [AW:0]   NEvt;
  logic [AW:0]   Occupancy;

  evt_buf_fifo #(.DW(DW), .AW(AW)) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .WrEn      (WrEn),
    .WrData    (WrData),
    .WrLast    (WrLast),
    .WrAbort   (WrAbort),
    .Full      (Full),
    .Overflow  (Overflow),
    .RdEn      (RdEn),
    .RdData    (RdData),
    .RdValid   (RdValid),
    .RdLast    (RdLast),
    .EvtAvail  (EvtAvail),
    .NEvt      (NEvt),
    .Occupancy (Occupancy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: committed words, the partial event, and output state.
  logic [DW:0]   cq[$];
  logic [DW:0]   pq[$];
  bit            dropping;
  bit            m_ovf;
  bit            e_valid;
  bit            e_last;
  logic [DW-1:0] e_data;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    pq.delete();
    dropping = 1'b0;
    m_ovf    = 1'b0;
    e_valid  = 1'b0;
    e_last   = 1'b0;
    e_data   = '0;
  endtask

  // Apply one clock edge to the model using the inputs seen at that edge.
  task automatic model_step();
    bit          full_pre;
    logic [DW:0] w;
    full_pre = ((cq.size() + pq.size()) == DEPTH);
    if (RdEn && cq.size() > 0) begin
      w       = cq.pop_front();
      e_valid = 1'b1;
      e_data  = w[DW-1:0];
      e_last  = w[DW];
    end else begin
      e_valid = 1'b0;
      e_last  = 1'b0;
    end
    if (dropping) begin
      if (WrAbort || (WrEn && WrLast)) dropping = 1'b0;
    end else if (pq.size() > 0 && WrAbort) begin
      pq.delete();
    end else if (WrEn) begin
      if (full_pre) begin
        m_ovf = 1'b1;
        pq.delete();
        if (!WrLast) dropping = 1'b1;
      end else begin
        pq.push_back({WrLast, WrData});
        if (WrLast) begin
          foreach (pq[k]) cq.push_back(pq[k]);
          pq.delete();
        end
      end
    end
  endtask

  function automatic int exp_nevt();
    int n;
    n = (e_valid && e_last) ? 1 : 0;
    foreach (cq[k]) if (cq[k][DW]) n++;
    return n;
  endfunction

  task automatic compare_all();
    check_val("rd_valid", RdValid, e_valid);
    if (e_valid) check_val("rd_data", RdData, e_data);
    check_val("rd_last", RdLast, e_valid & e_last);
    check_val("nevt", NEvt, exp_nevt());
    check_val("occupancy", Occupancy, cq.size() + pq.size());
    check_val("full", Full, (cq.size() + pq.size()) == DEPTH);
    check_val("evt_avail", EvtAvail, cq.size() > 0);
    check_val("overflow", Overflow, m_ovf);
  endtask

  task automatic step(input bit we, input logic [DW-1:0] d, input bit last,
                      input bit ab, input bit re);
    WrEn    = we;
    WrData  = d;
    WrLast  = last;
    WrAbort = ab;
    RdEn    = re;
    @(posedge Clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_full"}, Full, 0);
    check_val({tag, "_ovf"}, Overflow, 0);
    check_val({tag, "_rdvalid"}, RdValid, 0);
    check_val({tag, "_rdlast"}, RdLast, 0);
    check_val({tag, "_rddata"}, RdData, 0);
    check_val({tag, "_avail"}, EvtAvail, 0);
    check_val({tag, "_nevt"}, NEvt, 0);
    check_val({tag, "_occ"}, Occupancy, 0);
  endtask

  initial begin
    int vcnt;
    int nmax;
    int rd_pct;
    WrEn = 1'b0; WrData = '0; WrLast = 1'b0; WrAbort = 1'b0; RdEn = 1'b0;
    ResetN = 1'b0;
    model_reset();
    #3;
    check_reset_outputs("por");
    @(negedge Clock);
    ResetN = 1'b1;

    // 3-word event, committed only on the third edge, then read back.
    step(1'b1, 12'h001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h002, 1'b0, 1'b0, 1'b0);
    check_val("s1_avail_before", EvtAvail, 0);
    step(1'b1, 12'h003, 1'b1, 1'b0, 1'b0);
    check_val("s1_avail_after", EvtAvail, 1);
    check_val("s1_nevt1", NEvt, 1);
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
      if (RdValid) vcnt++;
    end
    check_val("s1_valid_cycles", vcnt, 3);
    check_val("s1_nevt0", NEvt, 0);

    // Abort beats a same-cycle WrEn&WrLast.
    step(1'b1, 12'h010, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h011, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h012, 1'b1, 1'b1, 1'b0);
    check_val("s2_occ", Occupancy, 0);
    check_val("s2_nevt", NEvt, 0);
    check_val("s2_avail", EvtAvail, 0);
    step(1'b1, 12'h020, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h021, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);

    // Overflow: 10-word event, then a 9-word event with no reads.
    for (int i = 0; i < 10; i++) step(1'b1, 12'(12'h100 + i), i == 9, 1'b0, 1'b0);
    for (int j = 0; j < 9; j++) begin
      step(1'b1, 12'(12'h200 + j), j == 8, 1'b0, 1'b0);
      if (j == 5) check_val("s3_full_w6", Full, 1);
      if (j == 6) begin
        check_val("s3_ovf_w7", Overflow, 1);
        check_val("s3_occ_w7", Occupancy, 10);
      end
    end
    check_val("s3_nevt", NEvt, 1);
    check_val("s3_occ_end", Occupancy, 10);
    for (int i = 0; i < 12; i++) step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);

    // Async reset mid-event and mid-read.
    for (int i = 0; i < 4; i++) step(1'b1, 12'(12'h300 + i), i == 3, 1'b0, 1'b0);
    step(1'b1, 12'h3a0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 12'h3a1, 1'b0, 1'b0, 1'b1);
    #2;
    ResetN = 1'b0;
    #1;
    check_reset_outputs("midrst");
    WrEn = 1'b0; WrLast = 1'b0; WrAbort = 1'b0; RdEn = 1'b0;
    model_reset();
    @(negedge Clock);
    ResetN = 1'b1;
    step(1'b1, 12'h3c0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 12'h3c1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);

    // Streaming one-word events with a continuously draining reader.
    nmax = 0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 12'(12'h400 + i * 3), 1'b1, 1'b0, 1'b1);
      if (int'(NEvt) > nmax) nmax = int'(NEvt);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
    check_val("s4_nevt_max_le2", nmax <= 2, 1);
    check_val("s4_ovf", Overflow, 0);
    check_val("s4_empty_rdvalid", RdValid, 0);

    // Randomized traffic with alternating slow and fast readers.
    rd_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) rd_pct = (rd_pct == 20) ? 90 : 20;
      step($urandom_range(99) < 60, 12'($urandom), $urandom_range(99) < 20,
           $urandom_range(99) < 3, $urandom_range(99) < rd_pct);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
